mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_step.sv | 31 +++
 rtl/mdu_iter.sv | 190 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Optional build macro MDU_EARLY_TERM_EN is consumed by mdu_iter.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add for multiply, restoring
// trial-subtract for divide. The caller picks which outputs to keep.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic [2*WIDTH-1:1]   acc,
    input  logic [WIDTH:0]       rem,
    output logic [WIDTH-1:0]     q_nxt,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic [WIDTH:0]       rem_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
        // MSB of trial is the borrow: set when shifted remainder < divisor
        trial = {rem, q[WIDTH-1]} - {2'b00, m};

        acc_nxt = {sum, acc[WIDTH-1:1]};
        rem_nxt = trial[WIDTH+1] ? {rem[WIDTH-1:0], q[WIDTH-1]} : trial[WIDTH:0];
        q_nxt   = is_div ? {q[WIDTH-2:0], ~trial[WIDTH+1]} : {1'b0, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_EARLY_TERM_EN to let multiplies exit once the multiplier is exhausted.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    mdu_op_e            op_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_op;
    logic [WIDTH-1:0]   step_q;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;
    logic               early_exit;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rmd_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic                    take_abs);
        if (take_abs && (x < 0))
            return -x;
        return x;
    endfunction

    assign op_in  = mdu_op_e'(op);
    assign div_op = op_is_div(op_q);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (div_op),
        .m       (m_q),
        .q       (q_q),
        .acc     (acc_q[2*WIDTH-1:1]),
        .rem     (rem_q),
        .q_nxt   (step_q),
        .acc_nxt (step_acc),
        .rem_nxt (step_rem)
    );

`ifdef MDU_EARLY_TERM_EN
    // Skipped iterations are pure right shifts; apply them all at once in FIX.
    assign early_exit = !div_op && (q_q == '0);
    assign prod       = acc_q >> (CNT_LAST - cnt_q);
`else
    assign early_exit = 1'b0;
    assign prod       = acc_q;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        neg_d   = neg_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        a_mag    = magnitude(a, op_is_signed(op_in));
        b_mag    = magnitude(b, op_is_signed(op_in));
        prod_fix = (op_q == MDU_MULT && neg_q) ? -prod : prod;
        quo_fix  = (op_q == MDU_DIV && neg_q) ? -q_q : q_q;
        rmd_fix  = (op_q == MDU_DIV && sa_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    state_d = RUN;
                    op_d    = op_in;
                    sa_d    = a[WIDTH-1];
                    neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    cnt_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                    busy_d  = 1'b1;
                    if (op_is_div(op_in)) begin
                        q_d = a_mag;
                        m_d = b_mag;
                    end else begin
                        q_d = b_mag;
                        m_d = a_mag;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST || early_exit) begin
                    state_d = FIX;
                end else begin
                    acc_d = step_acc;
                    q_d   = step_q;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (div_op) begin
                    hi_d = rmd_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            neg_q   <= neg_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: issue side pushes model results, a negedge
// monitor pops and compares on every done pulse.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wd = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pushed = 0;
    int dones = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           iss;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus the documented divide-by-zero rules.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] h, output logic [W-1:0] l, output int lat);
        longint          sa, sb_v, qq, rr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [W-1:0]    mag;
        int              steps;
        sa = $signed(av);
        sb_v = $signed(bv);
        ua = av;
        ub = bv;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin p = sa * sb_v; h = p[63:32]; l = p[31:0]; end
            2'b01: begin p = ua * ub;   h = p[63:32]; l = p[31:0]; end
            2'b10: begin
                if (bv == 0) begin
                    h = av;
                    l = (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
                end else begin
                    qq = sa / sb_v;
                    rr = sa % sb_v;
                    p = qq; l = p[31:0];
                    p = rr; h = p[31:0];
                end
            end
            default: begin
                if (bv == 0) begin
                    h = av;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = av / bv;
                    h = av % bv;
                end
            end
        endcase
        lat = W + 2;
`ifdef MDU_EARLY_TERM_EN
        if (o[1] == 1'b0) begin
            mag = (o == 2'b00 && bv[W-1]) ? -bv : bv;
            steps = 0;
            for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
            lat = steps + 2;
        end
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required no pending op (cycle %0d)", cyc);
            end else begin
                me = sb.pop_front();
                chk("hi", hi, me.hi);
                chk("lo", lo, me.lo);
                chk("latency", cyc - me.iss, me.lat);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit with_we);
        exp_t         e;
        int           n;
        logic [W-1:0] wv, h, l;
        int           lt;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {busy, done}, 2'b00);
        start = 1'b1;
        op = o;
        a = av;
        b = bv;
        wv = $urandom;
        if (with_we) begin
            hi_we = 1'b1;
            wd = wv;
        end
        model(o, av, bv, h, l, lt);
        e.hi = h;
        e.lo = l;
        e.lat = lt;
        @(posedge clk);
        #1;
        e.iss = cyc;
        sb.push_back(e);
        pushed++;
        chk("busy_after_start", busy, 1'b1);
        if (with_we) chk("hi_write_with_start", hi, wv);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, '0);
        chk("reset_lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        issue(MDU_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b0);
        issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b0);
        issue(MDU_MULTU, 32'h0000_0005, 32'h0000_0001, 1'b0);
        issue(MDU_MULTU, 32'h0000_0000, 32'h0000_0123, 1'b0);
        issue(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        drain();

        // Abort a divide partway through with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; a = 32'hFFFF_FFF9; b = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        @(negedge clk);
        reset = 1'b0;
        issue(MDU_MULTU, 32'd6, 32'd7, 1'b0);
        drain();

        // MTLO/MTHI in IDLE take effect; during RUN they are ignored.
        @(negedge clk);
        lo_we = 1'b1; wd = 32'h0000_1234;
        @(posedge clk); #1;
        chk("mtlo_idle", lo, 32'h0000_1234);
        @(negedge clk);
        lo_we = 1'b0; hi_we = 1'b1; wd = 32'h0000_5678;
        @(posedge clk); #1;
        chk("mthi_idle", hi, 32'h0000_5678);
        @(negedge clk);
        hi_we = 1'b0;
        issue(MDU_MULTU, 32'h0000_ABCD, 32'h8000_0003, 1'b0);
        repeat (3) @(negedge clk);
        lo_we = 1'b1; hi_we = 1'b1; wd = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("mtlo_run_ignored", lo, 32'h0000_1234);
        chk("mthi_run_ignored", hi, 32'h0000_5678);
        @(negedge clk);
        lo_we = 1'b0; hi_we = 1'b0;
        drain();

        // start held high while busy must not queue a second operation.
        issue(MDU_DIVU, $urandom, 32'h0000_0013, 1'b0);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; op = MDU_MULTU; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 4) == 0));
        drain();

        chk("done_pulse_count", dones, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
